// File: rtl/max7219_msg_seq.sv
// Message sequencer feeding the MAX7219 character display stage.
// Steps through a small buffer of 6-bit character codes, hands each one to
// the display stage over a call/done handshake, holds it for a programmable
// dwell time, then advances with wrap-around.
module max7219_msg_seq #(
   parameter logic [31:0] DWELL_CYCLES = 32'd50_000_000,
   parameter int          DEPTH        = 16,
   parameter int          AW           = 4
) (
   input  logic          CLOCK,
   input  logic          RST_n,
   input  logic          iEn,
   input  logic          iWrEn,
   input  logic [AW-1:0] iWrAddr,
   input  logic [5:0]    iWrData,
   input  logic [AW:0]   iLen,
   output logic          oCall,
   output logic [5:0]    oData,
   input  logic          iDone,
   output logic          oBusy,
   output logic          oWrap
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALL, S_DWELL} state_t;

   localparam logic [AW:0] LMAX    = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_L   = (AW+1)'(1);
   localparam logic [31:0] DW_LAST = DWELL_CYCLES - 32'd1;

   state_t        r_state;
   state_t        w_next;
   logic [5:0]    r_buf [DEPTH];
   logic [AW-1:0] r_idx;
   logic [31:0]   r_cnt;
   logic [5:0]    r_data;
   logic          r_wrap;

   logic [AW:0]   w_len;
   logic          w_run;
   logic          w_dw_end;
   logic          w_last;
   logic [AW-1:0] w_ld_idx;

   // Effective length is clamped to the buffer size; a zero length never runs.
   assign w_len    = (iLen > LMAX) ? LMAX : iLen;
   assign w_run    = iEn && (w_len != '0);
   assign w_dw_end = (r_cnt == DW_LAST);
   assign w_last   = ({1'b0, r_idx} == (w_len - ONE_L));
   // A shrunk length leaves the index out of range; restart at 0 silently.
   assign w_ld_idx = ({1'b0, r_idx} >= w_len) ? '0 : r_idx;

   assign oCall = (r_state == S_CALL);
   assign oBusy = (r_state != S_IDLE);
   assign oData = r_data;
   assign oWrap = r_wrap;

   // Message buffer: written in any state, never cleared by reset.
   always_ff @(posedge CLOCK) begin
      if (iWrEn) r_buf[iWrAddr] <= iWrData;
   end

   // State register.
   always_ff @(posedge CLOCK) begin
      if (!RST_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state: iEn is only consulted at character boundaries, so a
   // transfer or dwell in progress always runs to completion.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_run) w_next = S_LOAD;
         S_LOAD:  w_next = S_CALL;
         S_CALL:  if (iDone) w_next = S_DWELL;
         S_DWELL: if (w_dw_end) w_next = w_run ? S_LOAD : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: index, latched character, dwell counter and wrap pulse.
   always_ff @(posedge CLOCK) begin
      if (!RST_n) begin
         r_idx  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         case (r_state)
            S_LOAD: begin
               r_idx  <= w_ld_idx;
               r_data <= r_buf[w_ld_idx];
            end
            S_CALL: begin
               if (iDone) r_cnt <= '0;
            end
            S_DWELL: begin
               r_cnt <= r_cnt + 32'd1;
               if (w_dw_end) begin
                  if (w_last) begin
                     r_idx  <= '0;
                     r_wrap <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_max7219_msg_seq.sv
// Directed bench for max7219_msg_seq with a short dwell (10 cycles).
module tb_max7219_msg_seq;

   logic       CLOCK;
   logic       RST_n;
   logic       iEn;
   logic       iWrEn;
   logic [3:0] iWrAddr;
   logic [5:0] iWrData;
   logic [4:0] iLen;
   logic       oCall;
   logic [5:0] oData;
   logic       iDone;
   logic       oBusy;
   logic       oWrap;

   int checks   = 0;
   int failures = 0;

   max7219_msg_seq #(.DWELL_CYCLES(32'd10), .DEPTH(16), .AW(4)) dut (
      .CLOCK(CLOCK), .RST_n(RST_n), .iEn(iEn), .iWrEn(iWrEn),
      .iWrAddr(iWrAddr), .iWrData(iWrData), .iLen(iLen),
      .oCall(oCall), .oData(oData), .iDone(iDone),
      .oBusy(oBusy), .oWrap(oWrap)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // Advance n edges; inputs change and outputs are sampled 1 time unit later.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [5:0] d);
      iWrEn = 1'b1; iWrAddr = a; iWrData = d;
      tick(1);
      iWrEn = 1'b0;
   endtask

   // Called while oCall is sampled high: checks the presented code, keeps
   // oCall high for 'hold' samples, answers iDone, then measures how many
   // samples oCall stays low (bounded by 'limit') and counts oWrap pulses.
   task automatic xfer(input string tag, input int hold, input logic [5:0] exp_d,
                       input int exp_gap, input int exp_wraps, input bit stray,
                       input int limit);
      int bad;
      int n;
      int w;
      chk({tag, "_call"}, 32'(oCall), 32'd1);
      chk({tag, "_data"}, 32'(oData), 32'(exp_d));
      bad = 0;
      for (int i = 1; i < hold; i++) begin
         tick(1);
         if (oCall !== 1'b1 || oData !== exp_d) bad++;
      end
      chk({tag, "_hold"}, 32'(bad), 32'd0);
      iDone = 1'b1;
      tick(1);
      iDone = 1'b0;
      chk({tag, "_drop"}, 32'(oCall), 32'd0);
      n = 0;
      w = 0;
      while (oCall === 1'b0 && n < limit) begin
         n++;
         if (oWrap === 1'b1) w++;
         if (stray && n == 3) iDone = 1'b1;
         tick(1);
         iDone = 1'b0;
      end
      chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
      chk({tag, "_wrap"}, 32'(w), 32'(exp_wraps));
   endtask

   initial begin
      RST_n = 1'b0; iEn = 1'b1; iWrEn = 1'b0; iWrAddr = '0; iWrData = '0;
      iLen = '0; iDone = 1'b0;

      // Reset held with iEn high.
      tick(5);
      chk("rst_call", 32'(oCall), 32'd0);
      chk("rst_data", 32'(oData), 32'd0);
      chk("rst_busy", 32'(oBusy), 32'd0);
      chk("rst_wrap", 32'(oWrap), 32'd0);

      // Zero length never leaves IDLE.
      RST_n = 1'b1;
      tick(20);
      chk("len0_busy", 32'(oBusy), 32'd0);
      chk("len0_call", 32'(oCall), 32'd0);

      // Load A,B,C.
      iEn = 1'b0;
      wr(4'd0, 6'd10);
      wr(4'd1, 6'd11);
      wr(4'd2, 6'd12);

      // Start: LOAD after one edge, oCall after two.
      iLen = 5'd3;
      iEn  = 1'b1;
      tick(1);
      chk("lat_load_call", 32'(oCall), 32'd0);
      chk("lat_load_busy", 32'(oBusy), 32'd1);
      tick(1);
      chk("lat_call", 32'(oCall), 32'd1);

      // First pass.
      xfer("p1_i0", 5, 6'd10, 11, 0, 1'b0, 100);
      xfer("p1_i1", 5, 6'd11, 11, 0, 1'b0, 100);
      xfer("p1_i2", 5, 6'd12, 11, 1, 1'b0, 100);

      // Second pass: live write to the entry on display, long handshake.
      wr(4'd0, 6'd5);
      chk("live_call", 32'(oCall), 32'd1);
      chk("live_data", 32'(oData), 32'd10);
      xfer("p2_i0", 199, 6'd10, 11, 0, 1'b0, 100);
      // Stray iDone during dwell must not disturb timing or index.
      xfer("p2_i1", 5, 6'd11, 11, 0, 1'b1, 100);
      xfer("p2_i2", 5, 6'd12, 11, 1, 1'b0, 100);

      // Third pass: new buf[0] now visible.
      xfer("p3_i0", 5, 6'd5, 11, 0, 1'b0, 100);

      // Pause during CALL of index 1: finishes, then idles.
      iEn = 1'b0;
      xfer("pause_i1", 5, 6'd11, 40, 0, 1'b0, 40);
      chk("pause_busy", 32'(oBusy), 32'd0);

      // Resume from held index 2.
      iEn = 1'b1;
      tick(1);
      chk("resume_load", 32'(oCall), 32'd0);
      tick(1);
      chk("resume_call", 32'(oCall), 32'd1);
      chk("resume_data", 32'(oData), 32'd12);

      // Shrink while at index 2: next LOAD goes to 0 without oWrap.
      iLen = 5'd1;
      xfer("shrink_i2", 5, 6'd12, 11, 0, 1'b0, 100);
      // With length 1 every character end is a wrap.
      xfer("len1_i0", 5, 6'd5, 11, 1, 1'b0, 100);
      iLen = 5'd3;
      xfer("len3_i0", 5, 6'd5, 11, 0, 1'b0, 100);

      // Reset during CALL of index 1.
      chk("pre_rst_data", 32'(oData), 32'd11);
      RST_n = 1'b0;
      tick(1);
      chk("mid_rst_call", 32'(oCall), 32'd0);
      chk("mid_rst_busy", 32'(oBusy), 32'd0);
      chk("mid_rst_data", 32'(oData), 32'd0);
      RST_n = 1'b1;
      tick(2);
      chk("restart_call", 32'(oCall), 32'd1);
      chk("restart_data", 32'(oData), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
